// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  // Two-input round-robin pick: on a tie the requester not granted last wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates CPU (0) and loader (1) onto one memory port with burst locking,
// round-robin tie break, starvation-forced handover and one-cycle read return.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataIn,
  output logic              memWEn,
  input  logic [DATA_W-1:0] memDataOut
);

  localparam logic [7:0] STARVE_LAST = 8'(STARVE_LIMIT - 1);

  logic [1:0]        req_vec;
  logic [1:0]        lock_vec;
  logic [1:0]        we_vec;
  arb_state_t        state_reg, state_next;
  logic              last_reg, last_next;
  logic [7:0]        starve_reg, starve_next;
  logic [1:0]        gnt_next;
  logic [1:0]        gnt;
  logic [1:0]        rd_pend_reg;
  logic [1:0]        rvalid_vec;
  logic [DATA_W-1:0] rdata_vec [2];
  logic              pick;
  logic              owner;

  assign req_vec  = {req1, req0};
  assign lock_vec = {lock1, lock0};
  assign we_vec   = {we1, we0};

  always_comb begin
    state_next  = state_reg;
    last_next   = last_reg;
    starve_next = '0;
    gnt_next    = '0;
    pick        = rr_pick(req0, req1, last_reg);
    owner       = (state_reg == LOCK1);
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          gnt_next[pick] = 1'b1;
          last_next      = pick;
          if (lock_vec[pick]) state_next = pick ? LOCK1 : LOCK0;
        end
      end
      LOCK0, LOCK1: begin
        state_next = IDLE;
        if (req_vec[owner]) begin
          gnt_next[owner] = 1'b1;
          last_next       = owner;
          if (lock_vec[owner]) begin
            state_next = state_reg;
            // The waiter's patience runs out: drop the lock after this grant.
            if (req_vec[~owner]) begin
              if (starve_reg >= STARVE_LAST) state_next = IDLE;
              else starve_next = starve_reg + 8'd1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced quiet for the whole reset cycle, including a read return.
  assign gnt = gnt_next & {2{~reset}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      last_reg    <= 1'b1;
      starve_reg  <= '0;
      rd_pend_reg <= '0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      starve_reg  <= starve_next;
      rd_pend_reg <= gnt & ~we_vec;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      assign rvalid_vec[gi] = rd_pend_reg[gi] & ~reset;
      assign rdata_vec[gi]  = rvalid_vec[gi] ? memDataOut : '0;
    end
  endgenerate

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign rvalid0 = rvalid_vec[0];
  assign rvalid1 = rvalid_vec[1];
  assign rdata0  = rdata_vec[0];
  assign rdata1  = rdata_vec[1];

  always_comb begin
    memAddr   = '0;
    memDataIn = '0;
    memWEn    = 1'b0;
    if (gnt[0]) begin
      memAddr   = addr0;
      memDataIn = wdata0;
      memWEn    = we0;
    end else if (gnt[1]) begin
      memAddr   = addr1;
      memDataIn = wdata1;
      memWEn    = we1;
    end
  end

endmodule
